// File: rtl/cdb_pkg.sv
// Shared CDB definitions used by the arbiter, the reservation stations and the ROB.
// Default widths and the broadcast record, plus small helpers for
// round-robin pointer arithmetic.
package cdb_pkg;

   localparam int NUM_FU = 4;
   localparam int TAG_W  = 6;
   localparam int DATA_W = 32;

   // One broadcast on the common data bus, at the default widths.
   typedef struct packed {
      logic              valid;
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] data;
   } cdb_bcast_t;

   // (base + off) mod n, for base < n and off < n.
   function automatic int unsigned rr_add(input int unsigned base,
                                          input int unsigned off,
                                          input int unsigned n);
      int unsigned sum;
      sum = base + off;
      return (sum >= n) ? sum - n : sum;
   endfunction

   // Pointer position that follows a grant to requester idx.
   function automatic int unsigned rr_next(input int unsigned idx,
                                           input int unsigned n);
      return rr_add(idx, 1, n);
   endfunction

endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Round-robin pick: the first asserted request found when searching upward
// from ptr, modulo NUM_FU. Purely combinational; the caller owns the pointer.
module rr_arbiter #(
   parameter int NUM_FU = cdb_pkg::NUM_FU
) (
   input  logic [NUM_FU-1:0]         req,
   input  logic [$clog2(NUM_FU)-1:0] ptr,
   output logic [NUM_FU-1:0]         gnt
);
   import cdb_pkg::*;

   localparam int PTR_W = $clog2(NUM_FU);

   // Walk the requesters in priority order starting at ptr; the first valid one wins.
   always_comb begin
      // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
      logic              found;
      logic [PTR_W-1:0]  idx;
      gnt   = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < NUM_FU; k++) begin
         idx = PTR_W'(rr_add(int'(ptr), k, NUM_FU));
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks one functional-unit result per cycle in
// round-robin order and broadcasts it one cycle later from a register.
// Flush squashes the next broadcast; stall freezes the output register.
// Optional build macro CDB_PERF_EN adds grant and conflict counters.
module cdb_arbiter #(
   parameter int NUM_FU = cdb_pkg::NUM_FU,
   parameter int TAG_W  = cdb_pkg::TAG_W,
   parameter int DATA_W = cdb_pkg::DATA_W
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic                          flush_i,
   input  logic                          cdb_stall_i,
   input  logic [NUM_FU-1:0]             req_valid_i,
   input  logic [NUM_FU-1:0][TAG_W-1:0]  req_tag_i,
   input  logic [NUM_FU-1:0][DATA_W-1:0] req_data_i,
   output logic [NUM_FU-1:0]             req_ready_o,
   output logic                          cdb_valid_o,
   output logic [TAG_W-1:0]              cdb_tag_o,
   output logic [DATA_W-1:0]             cdb_data_o
`ifdef CDB_PERF_EN
   ,
   output logic [31:0]                   perf_grants_o,
   output logic [31:0]                   perf_conflicts_o
`endif
);
   import cdb_pkg::*;

   localparam int PTR_W = $clog2(NUM_FU);

   logic [PTR_W-1:0]  rr_q;
   logic [NUM_FU-1:0] arb_gnt;
   logic              grant_block;
   logic              xfer;
   logic [PTR_W-1:0]  gnt_idx;
   logic [TAG_W-1:0]  sel_tag;
   logic [DATA_W-1:0] sel_data;

   rr_arbiter #(
      .NUM_FU (NUM_FU)
   ) u_rr (
      .req (req_valid_i),
      .ptr (rr_q),
      .gnt (arb_gnt)
   );

   // Reset, flush and stall all suppress the grant; the arbiter's choice
   // already implies the corresponding valid bit is set.
   assign grant_block = reset_i | flush_i | cdb_stall_i;
   assign req_ready_o = grant_block ? '0 : arb_gnt;
   assign xfer        = |(req_ready_o & req_valid_i);

   // Encode the one-hot grant and select the winning tag/data.
   always_comb begin
      gnt_idx  = '0;
      sel_tag  = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_FU; i++) begin
         if (req_ready_o[i]) begin
            gnt_idx  = PTR_W'(i);
            sel_tag  = req_tag_i[i];
            sel_data = req_data_i[i];
         end
      end
   end

   // Round-robin pointer: moves just past the winner, holds otherwise.
   always_ff @(posedge clk_i or posedge reset_i) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (reset_i) begin
         rr_q <= '0;
      end else if (xfer) begin
         rr_q <= PTR_W'(rr_next(int'(gnt_idx), NUM_FU));
      end
   end

   // Broadcast register: flush kills valid ahead of stall, stall freezes everything,
   // tag/data only load on a transfer so idle cycles keep the last values.
   always_ff @(posedge clk_i or posedge reset_i) begin
      // NOTE: tag/data are reset too because downstream consumers observe them right after reset.
      if (reset_i) begin
         cdb_valid_o <= 1'b0;
         cdb_tag_o   <= '0;
         cdb_data_o  <= '0;
      end else if (flush_i) begin
         cdb_valid_o <= 1'b0;
      end else if (!cdb_stall_i) begin
         cdb_valid_o <= xfer;
         if (xfer) begin
            cdb_tag_o  <= sel_tag;
            cdb_data_o <= sel_data;
         end
      end
   end

`ifdef CDB_PERF_EN
   logic multi_req;

   // Two or more valid bits: clearing the lowest set bit still leaves one.
   assign multi_req = |(req_valid_i & (req_valid_i - NUM_FU'(1)));

   // Free-running performance counters; they wrap naturally at 2^32.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         perf_grants_o    <= '0;
         perf_conflicts_o <= '0;
      end else begin
         if (xfer) begin
            perf_grants_o <= perf_grants_o + 32'd1;
         end
         if (multi_req && !flush_i && !cdb_stall_i) begin
            perf_conflicts_o <= perf_conflicts_o + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: a table of directed single-cycle
// vectors followed by hand-written multi-cycle sequences.
module tb_cdb_arbiter;

   localparam int NUM_FU = 4;
   localparam int TAG_W  = 6;
   localparam int DATA_W = 32;

   logic                          clk_i = 1'b0;
   logic                          reset_i;
   logic                          flush_i;
   logic                          cdb_stall_i;
   logic [NUM_FU-1:0]             req_valid_i;
   logic [NUM_FU-1:0][TAG_W-1:0]  req_tag_i;
   logic [NUM_FU-1:0][DATA_W-1:0] req_data_i;
   logic [NUM_FU-1:0]             req_ready_o;
   logic                          cdb_valid_o;
   logic [TAG_W-1:0]              cdb_tag_o;
   logic [DATA_W-1:0]             cdb_data_o;
`ifdef CDB_PERF_EN
   logic [31:0]                   perf_grants_o;
   logic [31:0]                   perf_conflicts_o;
`endif

   cdb_arbiter #(
      .NUM_FU (NUM_FU),
      .TAG_W  (TAG_W),
      .DATA_W (DATA_W)
   ) dut (
      .clk_i            (clk_i),
      .reset_i          (reset_i),
      .flush_i          (flush_i),
      .cdb_stall_i      (cdb_stall_i),
      .req_valid_i      (req_valid_i),
      .req_tag_i        (req_tag_i),
      .req_data_i       (req_data_i),
      .req_ready_o      (req_ready_o),
      .cdb_valid_o      (cdb_valid_o),
      .cdb_tag_o        (cdb_tag_o),
      .cdb_data_o       (cdb_data_o)
`ifdef CDB_PERF_EN
      ,
      .perf_grants_o    (perf_grants_o),
      .perf_conflicts_o (perf_conflicts_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic             flush;
      logic             stall;
      logic [3:0]       valid;
      logic [3:0]       exp_ready;
      logic             exp_cv;
      logic [TAG_W-1:0] exp_tag;
      logic [31:0]      exp_data;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_fu(input int i, input logic [TAG_W-1:0] t, input logic [31:0] d);
      req_tag_i[i]  = t;
      req_data_i[i] = d;
   endtask

   task automatic check_cdb(input string name, input logic v, input logic [TAG_W-1:0] t,
                            input logic [31:0] d);
      check({name, " cdb_valid"}, 64'(cdb_valid_o), 64'(v));
      check({name, " cdb_tag"},   64'(cdb_tag_o),   64'(t));
      check({name, " cdb_data"},  64'(cdb_data_o),  64'(d));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // flush stall valid  ready  cv  tag    data   (rr pointer after the step in the comment)
      vecs[0]  = '{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 6'h00, 32'h0000_0000}; // rr0
      vecs[1]  = '{1'b0, 1'b0, 4'b0100, 4'b0100, 1'b1, 6'h12, 32'hC0DE_0002}; // rr3
      vecs[2]  = '{1'b0, 1'b0, 4'b1111, 4'b1000, 1'b1, 6'h13, 32'hC0DE_0003}; // rr0
      vecs[3]  = '{1'b0, 1'b0, 4'b1111, 4'b0001, 1'b1, 6'h10, 32'hC0DE_0000}; // rr1
      vecs[4]  = '{1'b0, 1'b0, 4'b0101, 4'b0100, 1'b1, 6'h12, 32'hC0DE_0002}; // rr3
      vecs[5]  = '{1'b0, 1'b0, 4'b0011, 4'b0001, 1'b1, 6'h10, 32'hC0DE_0000}; // rr1 (wrap)
      vecs[6]  = '{1'b0, 1'b1, 4'b0011, 4'b0000, 1'b1, 6'h10, 32'hC0DE_0000}; // stall holds
      vecs[7]  = '{1'b1, 1'b1, 4'b0010, 4'b0000, 1'b0, 6'h10, 32'hC0DE_0000}; // flush wins
      vecs[8]  = '{1'b0, 1'b0, 4'b0010, 4'b0010, 1'b1, 6'h11, 32'hC0DE_0001}; // rr2
      vecs[9]  = '{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 6'h11, 32'hC0DE_0001}; // idle holds
      vecs[10] = '{1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0, 6'h11, 32'hC0DE_0001}; // flush
      vecs[11] = '{1'b0, 1'b0, 4'b1111, 4'b0100, 1'b1, 6'h12, 32'hC0DE_0002}; // rr held at 2

      reset_i     = 1'b1;
      flush_i     = 1'b0;
      cdb_stall_i = 1'b0;
      req_valid_i = 4'b1111;
      for (int i = 0; i < NUM_FU; i++) set_fu(i, TAG_W'(6'h10 + i), 32'hC0DE_0000 + i);

      // Reset state, with requests pending during reset.
      cyc();
      cyc();
      check("reset ready", 64'(req_ready_o), 64'h0);
      check_cdb("reset", 1'b0, '0, '0);
      req_valid_i = 4'b0000;
      reset_i     = 1'b0;

      // Table-driven vectors.
      for (int i = 0; i < 12; i++) begin
         flush_i     = vecs[i].flush;
         cdb_stall_i = vecs[i].stall;
         req_valid_i = vecs[i].valid;
         #1;
         check($sformatf("vec%0d ready", i), 64'(req_ready_o), 64'(vecs[i].exp_ready));
         cyc();
         check_cdb($sformatf("vec%0d", i), vecs[i].exp_cv, vecs[i].exp_tag, vecs[i].exp_data);
      end
      flush_i     = 1'b0;
      cdb_stall_i = 1'b0;

      // FU2 alone: same-cycle grant, broadcast one edge later.
      set_fu(2, 6'd5, 32'hDEAD_BEEF);
      req_valid_i = 4'b0100;
      #1;
      check("fu2 ready", 64'(req_ready_o), 64'h4);
      cyc();
      check_cdb("fu2", 1'b1, 6'd5, 32'hDEAD_BEEF);

      // Reset while a broadcast is on the bus: clears immediately.
      reset_i     = 1'b1;
      req_valid_i = 4'b1111;
      #1;
      check("midreset ready", 64'(req_ready_o), 64'h0);
      check_cdb("midreset", 1'b0, '0, '0);
      cyc();
      cyc();
      reset_i = 1'b0;

      // All four valid from rr=0: strict rotation 0,1,2,3,0,1,2,3.
      for (int k = 0; k < 8; k++) begin
         #1;
         check($sformatf("rotate%0d ready", k), 64'(req_ready_o), 64'(4'b0001 << (k % 4)));
         cyc();
      end

      // Stall for three cycles with FU1 waiting; broadcast of FU3 stays frozen.
      set_fu(3, 6'd7, 32'h0000_0033);
      set_fu(1, 6'h21, 32'h0000_1111);
      req_valid_i = 4'b1000;
      #1;
      check("pre-stall ready", 64'(req_ready_o), 64'h8);
      cyc();
      check_cdb("pre-stall", 1'b1, 6'd7, 32'h33);
      cdb_stall_i = 1'b1;
      req_valid_i = 4'b0010;
      for (int k = 0; k < 3; k++) begin
         #1;
         check($sformatf("stall%0d ready", k), 64'(req_ready_o), 64'h0);
         cyc();
         check_cdb($sformatf("stall%0d", k), 1'b1, 6'd7, 32'h33);
      end
      cdb_stall_i = 1'b0;
      #1;
      check("post-stall ready", 64'(req_ready_o), 64'h2);
      cyc();
      check_cdb("post-stall", 1'b1, 6'h21, 32'h1111);

      // Flush and stall together: no grant, valid drops, pointer stays at 2.
      flush_i     = 1'b1;
      cdb_stall_i = 1'b1;
      req_valid_i = 4'b0001;
      #1;
      check("flush+stall ready", 64'(req_ready_o), 64'h0);
      cyc();
      check_cdb("flush+stall", 1'b0, 6'h21, 32'h1111);
      flush_i     = 1'b0;
      cdb_stall_i = 1'b0;
      req_valid_i = 4'b0011;
      #1;
      check("ptr held ready", 64'(req_ready_o), 64'h1);
      cyc();
      check_cdb("ptr held", 1'b1, 6'h10, 32'hC0DE_0000);

      // A lone requester is granted back to back.
      req_valid_i = 4'b0010;
      for (int k = 0; k < 4; k++) begin
         #1;
         check($sformatf("single%0d ready", k), 64'(req_ready_o), 64'h2);
         cyc();
         check_cdb($sformatf("single%0d", k), 1'b1, 6'h21, 32'h1111);
      end
      req_valid_i = 4'b0000;

`ifdef CDB_PERF_EN
      // Two requesters for nine cycles, FU1 alone on the tenth.
      reset_i = 1'b1;
      cyc();
      reset_i = 1'b0;
      check("perf reset grants", 64'(perf_grants_o), 64'd0);
      check("perf reset conflicts", 64'(perf_conflicts_o), 64'd0);
      for (int c = 1; c <= 10; c++) begin
         req_valid_i = (c < 10) ? 4'b0011 : 4'b0010;
         cyc();
      end
      req_valid_i = 4'b0000;
      #1;
      check("perf grants", 64'(perf_grants_o), 64'd10);
      check("perf conflicts", 64'(perf_conflicts_o), 64'd9);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
